// File: rtl/regfile_pkg.sv
// Shared constants and the per-register pending-counter update rule
// for the scoreboarded register file.
package regfile_pkg;

  localparam int REG_ZERO   = 0;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;
  localparam int DEF_CNT_W  = 2;

  // Flush wins; a same-cycle issue and writeback cancel; an orphan writeback never underflows.
  function automatic int unsigned pend_next(input int unsigned cur,
                                            input logic        inc,
                                            input logic        dec,
                                            input logic        flush);
    if (flush)
      return 0;
    if (inc && !dec)
      return cur + 1;
    if (dec && !inc && cur != 0)
      return cur - 1;
    return cur;
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Bundle of the ID / EX / WB signals seen by the register file.
// The pipeline side is the master and the register file is the slave.
interface regfile_sb_if #(
  parameter int DATA_W = regfile_pkg::DEF_DATA_W,
  parameter int ADDR_W = regfile_pkg::DEF_ADDR_W,
  parameter int NUM_RD = regfile_pkg::DEF_NUM_RD
);
  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic                     issue_en;
  logic [ADDR_W-1:0]        issue_addr;
  logic                     ex_en;
  logic                     ex_ready;
  logic [ADDR_W-1:0]        ex_addr;
  logic [DATA_W-1:0]        ex_data;
  logic                     wb_en;
  logic [ADDR_W-1:0]        wb_addr;
  logic [DATA_W-1:0]        wb_data;
  logic                     flush;
  logic                     stall;
  logic                     sb_err;

  modport master (
    output rd_en, rd_addr, issue_en, issue_addr,
           ex_en, ex_ready, ex_addr, ex_data,
           wb_en, wb_addr, wb_data, flush,
    input  rd_data, stall, sb_err
  );

  modport slave (
    input  rd_en, rd_addr, issue_en, issue_addr,
           ex_en, ex_ready, ex_addr, ex_data,
           wb_en, wb_addr, wb_data, flush,
    output rd_data, stall, sb_err
  );
endinterface

// File: rtl/rf_read_port.sv
// One read port: EX forward, MEM-writer stall, WB bypass, then array.
// Purely combinational; the top supplies the addressed counter and array word.
module rf_read_port #(
  parameter int DATA_W = regfile_pkg::DEF_DATA_W,
  parameter int ADDR_W = regfile_pkg::DEF_ADDR_W,
  parameter int CNT_W  = regfile_pkg::DEF_CNT_W
) (
  input  logic              i_en,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_ex_en,
  input  logic              i_ex_ready,
  input  logic [ADDR_W-1:0] i_ex_addr,
  input  logic [DATA_W-1:0] i_ex_data,
  input  logic              i_wb_en,
  input  logic [ADDR_W-1:0] i_wb_addr,
  input  logic [DATA_W-1:0] i_wb_data,
  input  logic [CNT_W-1:0]  i_pend,
  input  logic [DATA_W-1:0] i_arr_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_stall
);

  logic w_ex_hit;
  logic w_wb_hit;

  always_comb begin
    o_data   = '0;
    o_stall  = 1'b0;
    w_ex_hit = i_ex_en && (i_ex_addr == i_addr);
    w_wb_hit = i_wb_en && (i_wb_addr == i_addr);
    if (!i_en || i_addr == '0) begin
      o_data = '0;
    end else if (w_ex_hit) begin
      if (i_ex_ready)
        o_data = i_ex_data;
      else
        o_stall = 1'b1;
    end else if (i_pend > CNT_W'(w_wb_hit)) begin
      // An older writer than the one in WB is still parked in MEM.
      o_stall = 1'b1;
    end else if (w_wb_hit) begin
      o_data = i_wb_data;
    end else begin
      o_data = i_arr_data;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with per-register in-flight writer counters, forwarding
// read ports, structural/hazard stall and a sticky orphan-writeback flag.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD,
  parameter int CNT_W  = DEF_CNT_W
) (
  input logic         clk,
  input logic         rst,
  regfile_sb_if.slave bus
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [DATA_W-1:0] r_mem  [NUM_REGS];
  logic [CNT_W-1:0]  r_pend [NUM_REGS];
  logic              r_sb_err;

  logic [DATA_W-1:0] w_port_data  [NUM_RD];
  logic              w_port_stall [NUM_RD];
  logic              w_hazard;
  logic              w_struct_stall;
  logic              w_stall;
  logic              w_iss;
  logic              w_wb_orphan;
  logic [NUM_RD*DATA_W-1:0] w_rd_data;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    logic [ADDR_W-1:0] w_addr;
    assign w_addr = bus.rd_addr[p*ADDR_W +: ADDR_W];

    rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_port (
      .i_en       (bus.rd_en[p]),
      .i_addr     (w_addr),
      .i_ex_en    (bus.ex_en),
      .i_ex_ready (bus.ex_ready),
      .i_ex_addr  (bus.ex_addr),
      .i_ex_data  (bus.ex_data),
      .i_wb_en    (bus.wb_en),
      .i_wb_addr  (bus.wb_addr),
      .i_wb_data  (bus.wb_data),
      .i_pend     (r_pend[w_addr]),
      .i_arr_data (r_mem[w_addr]),
      .o_data     (w_port_data[p]),
      .o_stall    (w_port_stall[p])
    );
  end

  always_comb begin
    w_hazard  = 1'b0;
    w_rd_data = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      w_hazard = w_hazard | w_port_stall[p];
      w_rd_data[p*DATA_W +: DATA_W] = w_port_data[p];
    end
  end

  // A full counter blocks another issue unless WB retires one of its writers this cycle.
  assign w_struct_stall = bus.issue_en && (bus.issue_addr != '0) &&
                          (r_pend[bus.issue_addr] == CNT_MAX) &&
                          !(bus.wb_en && (bus.wb_addr == bus.issue_addr));
  assign w_stall     = w_hazard | w_struct_stall;
  assign w_iss       = bus.issue_en && !w_stall && (bus.issue_addr != '0);
  assign w_wb_orphan = bus.wb_en && (bus.wb_addr != '0) &&
                       (r_pend[bus.wb_addr] == '0) && !bus.flush;

  assign bus.stall   = rst ? 1'b0 : w_stall;
  assign bus.rd_data = rst ? '0 : w_rd_data;
  assign bus.sb_err  = r_sb_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_mem[r]  <= '0;
        r_pend[r] <= '0;
      end
      r_sb_err <= 1'b0;
    end else begin
      for (int r = REG_ZERO + 1; r < NUM_REGS; r++) begin
        if (bus.wb_en && (bus.wb_addr == ADDR_W'(r)))
          r_mem[r] <= bus.wb_data;
        r_pend[r] <= CNT_W'(pend_next(32'(r_pend[r]),
                                      w_iss && (bus.issue_addr == ADDR_W'(r)),
                                      bus.wb_en && (bus.wb_addr == ADDR_W'(r)),
                                      bus.flush));
      end
      if (w_wb_orphan)
        r_sb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: directed hazard scenarios, async reset,
// then randomized traffic against an abstract register/counter model.
module tb_regfile_sb;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NR   = 2;
  localparam int CW   = 2;
  localparam int NREG = 32;
  localparam int PMAX = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit          en0, en1;
    int          a0, a1;
    bit          iss;
    int          ia;
    bit          exEn, exRdy;
    int          exA;
    logic [31:0] exD;
    bit          wbEn;
    int          wbA;
    logic [31:0] wbD;
    bit          flush;
  } stim_t;

  typedef struct {
    logic [31:0] d0, d1;
    bit          stall, err;
    string       tag;
  } exp_t;

  exp_t        sbQ[$];
  event        evCheck;
  int          nChecks = 0;
  int          nFail   = 0;
  logic [31:0] mMem  [NREG];
  int          mPend [NREG];
  bit          mErr;

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  function automatic void modelReset();
    for (int r = 0; r < NREG; r++) begin
      mMem[r]  = '0;
      mPend[r] = 0;
    end
    mErr = 1'b0;
  endfunction

  // Expected read result for one port, straight from the forwarding rules.
  function automatic void readModel(input bit en, input int a, input stim_t s,
                                    output logic [31:0] d, output bit st);
    bit wbHit;
    d  = '0;
    st = 1'b0;
    if (!en || a == 0) return;
    if (s.exEn && s.exA == a) begin
      if (s.exRdy) d = s.exD;
      else st = 1'b1;
      return;
    end
    wbHit = s.wbEn && s.wbA == a;
    if (mPend[a] - (wbHit ? 1 : 0) > 0) begin
      st = 1'b1;
      return;
    end
    d = wbHit ? s.wbD : mMem[a];
  endfunction

  function automatic void modelUpdate(input stim_t s, input bit stalled);
    bit iss;
    bit sameReg;
    iss = s.iss && !stalled && s.ia != 0;
    if (s.wbEn && s.wbA != 0) mMem[s.wbA] = s.wbD;
    if (s.flush) begin
      for (int r = 0; r < NREG; r++) mPend[r] = 0;
    end else begin
      if (s.wbEn && s.wbA != 0 && mPend[s.wbA] == 0) mErr = 1'b1;
      sameReg = iss && s.wbEn && s.wbA == s.ia;
      if (!sameReg) begin
        if (iss) mPend[s.ia]++;
        if (s.wbEn && s.wbA != 0 && mPend[s.wbA] > 0) mPend[s.wbA]--;
      end
    end
  endfunction

  task automatic driveInputs(input stim_t s);
    logic [AW-1:0] a0, a1;
    a0 = AW'(s.a0);
    a1 = AW'(s.a1);
    bus.rd_en      = {s.en1, s.en0};
    bus.rd_addr    = {a1, a0};
    bus.issue_en   = s.iss;
    bus.issue_addr = AW'(s.ia);
    bus.ex_en      = s.exEn;
    bus.ex_ready   = s.exRdy;
    bus.ex_addr    = AW'(s.exA);
    bus.ex_data    = s.exD;
    bus.wb_en      = s.wbEn;
    bus.wb_addr    = AW'(s.wbA);
    bus.wb_data    = s.wbD;
    bus.flush      = s.flush;
  endtask

  // One full cycle: drive after the falling edge, publish the expectation, commit the model at the rising edge.
  task automatic applyStimulus(input stim_t s, input string tag);
    exp_t e;
    bit   st0, st1, sst;
    @(negedge clk);
    driveInputs(s);
    #1;
    readModel(s.en0, s.a0, s, e.d0, st0);
    readModel(s.en1, s.a1, s, e.d1, st1);
    sst = s.iss && s.ia != 0 && mPend[s.ia] == PMAX && !(s.wbEn && s.wbA == s.ia);
    e.stall = st0 | st1 | sst;
    e.err   = mErr;
    e.tag   = tag;
    sbQ.push_back(e);
    ->evCheck;
    @(posedge clk);
    modelUpdate(s, e.stall);
  endtask

  task automatic checkOutput(input string name, input string tag,
                             input logic [31:0] act, input logic [31:0] expv);
    nChecks++;
    if (act !== expv) begin
      nFail++;
      $display("[TB] FAIL %s/%s: got 0x%08h, expected 0x%08h", tag, name, act, expv);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(evCheck);
      if (sbQ.size() == 0) begin
        nChecks++;
        nFail++;
        $display("[TB] FAIL scoreboard: got output with empty queue, expected pending entry");
      end else begin
        e = sbQ.pop_front();
        checkOutput("rd_data0", e.tag, bus.rd_data[31:0], e.d0);
        checkOutput("rd_data1", e.tag, bus.rd_data[63:32], e.d1);
        checkOutput("stall", e.tag, {31'b0, bus.stall}, {31'b0, e.stall});
        checkOutput("sb_err", e.tag, {31'b0, bus.sb_err}, {31'b0, e.err});
      end
    end
  end

  // Reset lands between edges while forwarding and hazards are active.
  task automatic pulseReset();
    stim_t s;
    exp_t  e;
    s = idle();
    s.en0 = 1; s.a0 = 5; s.exEn = 1; s.exRdy = 1; s.exA = 5; s.exD = 32'h33;
    s.en1 = 1; s.a1 = 10;
    s.wbEn = 1; s.wbA = 6; s.wbD = 32'h44;
    @(negedge clk);
    driveInputs(s);
    #2 rst = 1'b1;
    #1;
    e.d0 = '0; e.d1 = '0; e.stall = 1'b0; e.err = 1'b0; e.tag = "async_reset";
    sbQ.push_back(e);
    ->evCheck;
    @(posedge clk);
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    driveInputs(idle());
  endtask

  initial begin : stimulus
    stim_t s;
    int    pendList[$];
    modelReset();
    driveInputs(idle());
    repeat (2) @(negedge clk);
    rst = 1'b0;

    s = idle(); s.en0 = 1; s.a0 = 3; s.en1 = 1; s.a1 = 5;
    applyStimulus(s, "after_reset");

    s = idle(); s.iss = 1; s.ia = 3;
    applyStimulus(s, "issue_r3");
    s = idle(); s.wbEn = 1; s.wbA = 3; s.wbD = 32'hA5; s.en0 = 1; s.a0 = 3;
    applyStimulus(s, "bypass_r3");
    s = idle(); s.en0 = 1; s.a0 = 3;
    applyStimulus(s, "array_r3");

    s = idle(); s.iss = 1; s.ia = 5;
    applyStimulus(s, "issue_r5");
    s = idle(); s.exEn = 1; s.exA = 5; s.en1 = 1; s.a1 = 5;
    applyStimulus(s, "ex_not_ready");
    s.exRdy = 1; s.exD = 32'h77;
    applyStimulus(s, "ex_forward");
    s = idle(); s.wbEn = 1; s.wbA = 5; s.wbD = 32'h77;
    applyStimulus(s, "wb_r5");

    s = idle(); s.iss = 1; s.ia = 7;
    applyStimulus(s, "issue_r7_a");
    applyStimulus(s, "issue_r7_b");
    s = idle(); s.en0 = 1; s.a0 = 7;
    applyStimulus(s, "mem_hazard");
    s.wbEn = 1; s.wbA = 7; s.wbD = 32'h11;
    applyStimulus(s, "wb1_still_stall");
    s = idle(); s.en0 = 1; s.a0 = 7;
    applyStimulus(s, "one_left");
    s.wbEn = 1; s.wbA = 7; s.wbD = 32'h22;
    applyStimulus(s, "wb2_bypass");
    s = idle(); s.en0 = 1; s.a0 = 7;
    applyStimulus(s, "r7_final");

    s = idle(); s.iss = 1; s.ia = 9;
    for (int i = 0; i < 3; i++) applyStimulus(s, "issue_r9");
    applyStimulus(s, "saturated");
    s.wbEn = 1; s.wbA = 9; s.wbD = 32'h9;
    applyStimulus(s, "sat_with_wb");
    s = idle(); s.en0 = 1; s.a0 = 9;
    applyStimulus(s, "r9_still_full");
    s = idle(); s.flush = 1;
    applyStimulus(s, "flush_all");

    s = idle(); s.iss = 1; s.ia = 4;
    applyStimulus(s, "issue_r4_a");
    applyStimulus(s, "issue_r4_b");
    s = idle(); s.flush = 1; s.wbEn = 1; s.wbA = 4; s.wbD = 32'h5;
    applyStimulus(s, "flush_wb_r4");
    s = idle(); s.en0 = 1; s.a0 = 4;
    applyStimulus(s, "r4_after_flush");
    s.wbEn = 1; s.wbA = 4; s.wbD = 32'h6;
    applyStimulus(s, "orphan_wb");
    s = idle(); s.en0 = 1; s.a0 = 4;
    applyStimulus(s, "err_set");
    applyStimulus(idle(), "err_held");

    s = idle(); s.iss = 1; s.ia = 10;
    applyStimulus(s, "issue_r10");
    pulseReset();
    for (int r = 1; r < NREG; r += 2) begin
      s = idle(); s.en0 = 1; s.a0 = r; s.en1 = 1; s.a1 = (r + 1) % NREG;
      applyStimulus(s, "post_reset_sweep");
    end

    for (int i = 0; i < 400; i++) begin
      pendList.delete();
      for (int r = 1; r < 16; r++) if (mPend[r] > 0) pendList.push_back(r);
      s = idle();
      s.en0 = 1'($urandom_range(0, 1)); s.a0 = $urandom_range(0, 15);
      s.en1 = 1'($urandom_range(0, 1)); s.a1 = $urandom_range(0, 15);
      s.iss = 1'($urandom_range(0, 1)); s.ia = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) begin
        s.exEn  = 1;
        s.exRdy = 1'($urandom_range(0, 1));
        s.exA   = (pendList.size() > 0 && $urandom_range(0, 1) == 1) ?
                  pendList[$urandom_range(0, pendList.size() - 1)] : $urandom_range(0, 15);
        s.exD   = $urandom;
      end
      if (pendList.size() > 0 && $urandom_range(0, 9) < 4) begin
        s.wbEn = 1;
        s.wbA  = pendList[$urandom_range(0, pendList.size() - 1)];
        s.wbD  = $urandom;
      end
      s.flush = ($urandom_range(0, 31) == 0);
      applyStimulus(s, "random");
    end

    @(negedge clk);
    nChecks++;
    if (sbQ.size() != 0) begin
      nFail++;
      $display("[TB] FAIL drain: got %0d queued entries, expected 0", sbQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
